// File: rtl/fft_pkg.sv
// fft_pkg: constants, types, state encoding and the bit-reversal helper shared
// by the FFT sequencer and its address generator.
package fft_pkg;

  localparam int N_LOG2 = 9;
  localparam int N      = 512;

  typedef logic [N_LOG2-1:0] addr_t;
  typedef logic [N_LOG2-2:0] tw_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Mirror a 9-bit sample index (load order for decimation-in-time).
  function automatic addr_t bitrev9(input addr_t a);
    return {a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7], a[8]};
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational butterfly index generator. For stage s and
// butterfly b it yields the A/B sample addresses and the twiddle ROM address.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [3:0] stage_i,
  input  logic [7:0] bfly_i,
  output addr_t      ia_o,
  output addr_t      ib_o,
  output tw_addr_t   tw_o
);

  addr_t span_s;
  addr_t j_s;
  addr_t grp_s;

  // Split b into group and in-group offset, then place the pair span apart
  always_comb begin
    span_s = 9'd1 << stage_i;
    j_s    = {1'b0, bfly_i} & (span_s - 9'd1);
    grp_s  = ({1'b0, bfly_i} >> stage_i) << (stage_i + 4'd1);
    ia_o   = grp_s | j_s;
    ib_o   = ia_o + span_s;
    tw_o   = tw_addr_t'(j_s << (4'd8 - stage_i));
  end

endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: control sequencer for the 512-point in-place radix-2 FFT.
// Loads samples bit-reversed, runs 9 stages of 256 two-cycle butterflies with
// a WB_LAT-deep write-back delay line, and pulses done at the end.
// Build option FFT_UNLOAD_EN compiles in the UNLOAD state that streams the
// RAM contents out; without it stage 8 drains straight into DONE.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int WB_LAT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       load_valid,
  output logic       busy,
  output logic       done,
  output logic       wr_sel,
  output logic       ram_write,
  output logic [8:0] write_address,
  output logic [8:0] read_address,
  output logic [7:0] twiddle_address,
  output logic       bfly_start,
  output logic       out_valid
);

  state_e            state_q;
  addr_t             load_cnt_q;
  logic [3:0]        stage_q;
  logic [7:0]        bfly_q;
  logic              ph_q;
  logic [4:0]        drain_cnt_q;
  logic              rd_is_a_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_sel_q;
  logic              ram_write_q;
  logic              bfly_start_q;
  addr_t             wr_addr_q;
  addr_t             rd_addr_q;
  tw_addr_t          tw_q;
  logic [WB_LAT-1:0] dl_vld_q;
  addr_t             dl_addr_q [WB_LAT];
  addr_t             ia_s;
  addr_t             ib_s;
  tw_addr_t          tw_s;
  logic              push_vld_s;
  addr_t             push_addr_s;
`ifdef FFT_UNLOAD_EN
  logic [9:0]        unl_cnt_q;
  logic              rd_unl_q;
  logic              out_valid_q;
`endif

  fft_addr_gen u_addr_gen (
    .stage_i (stage_q),
    .bfly_i  (bfly_q),
    .ia_o    (ia_s),
    .ib_o    (ib_s),
    .tw_o    (tw_s)
  );

  // Address entering the write-back line: A on phase 0, B on phase 1
  always_comb begin
    push_vld_s  = 1'b0;
    push_addr_s = 9'd0;
    if (state_q == ST_COMPUTE) begin
      push_vld_s  = 1'b1;
      push_addr_s = ph_q ? ib_s : ia_s;
    end else begin
      push_vld_s  = 1'b0;
      push_addr_s = 9'd0;
    end
  end

  // Write-back delay line; keeps shifting through DRAIN so the last B lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_vld_q <= '0;
      for (int k = 0; k < WB_LAT; k++) dl_addr_q[k] <= 9'd0;
    end else begin
      dl_vld_q     <= {dl_vld_q[WB_LAT-2:0], push_vld_s};
      dl_addr_q[0] <= push_addr_s;
      for (int k = 1; k < WB_LAT; k++) dl_addr_q[k] <= dl_addr_q[k-1];
    end
  end

  // Sequencer FSM with its counters and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      load_cnt_q   <= 9'd0;
      stage_q      <= 4'd0;
      bfly_q       <= 8'd0;
      ph_q         <= 1'b0;
      drain_cnt_q  <= 5'd0;
      rd_is_a_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_sel_q     <= 1'b0;
      ram_write_q  <= 1'b0;
      bfly_start_q <= 1'b0;
      wr_addr_q    <= 9'd0;
      rd_addr_q    <= 9'd0;
      tw_q         <= 8'd0;
`ifdef FFT_UNLOAD_EN
      unl_cnt_q    <= 10'd0;
      rd_unl_q     <= 1'b0;
      out_valid_q  <= 1'b0;
`endif
    end else begin
      // Defaults: butterfly writes come out of the delay line
      done_q       <= 1'b0;
      rd_is_a_q    <= 1'b0;
      bfly_start_q <= rd_is_a_q;
      wr_sel_q     <= 1'b0;
      ram_write_q  <= dl_vld_q[WB_LAT-1];
      wr_addr_q    <= dl_addr_q[WB_LAT-1];
`ifdef FFT_UNLOAD_EN
      rd_unl_q     <= 1'b0;
      out_valid_q  <= rd_unl_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            load_cnt_q <= 9'd0;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            ram_write_q <= 1'b1;
            wr_sel_q    <= 1'b1;
            wr_addr_q   <= bitrev9(load_cnt_q);
            load_cnt_q  <= load_cnt_q + 9'd1;
            if (load_cnt_q == addr_t'(N - 1)) begin
              state_q <= ST_COMPUTE;
              stage_q <= 4'd0;
              bfly_q  <= 8'd0;
              ph_q    <= 1'b0;
            end
          end
        end
        ST_COMPUTE: begin
          rd_addr_q <= push_addr_s;
          tw_q      <= tw_s;
          rd_is_a_q <= ~ph_q;
          ph_q      <= ~ph_q;
          if (ph_q) begin
            bfly_q <= bfly_q + 8'd1;
            if (bfly_q == 8'd255) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= 5'd0;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 5'd1;
          if (drain_cnt_q == 5'(WB_LAT - 1)) begin
            if (stage_q == 4'd8) begin
`ifdef FFT_UNLOAD_EN
              state_q   <= ST_UNLOAD;
              unl_cnt_q <= 10'd0;
`else
              state_q   <= ST_DONE;
`endif
            end else begin
              stage_q <= stage_q + 4'd1;
              state_q <= ST_COMPUTE;
            end
          end
        end
        ST_UNLOAD: begin
`ifdef FFT_UNLOAD_EN
          // One extra pass after the 512th read lets done trail the last out_valid
          if (unl_cnt_q == 10'd512) begin
            state_q <= ST_DONE;
          end else begin
            rd_addr_q <= unl_cnt_q[8:0];
            rd_unl_q  <= 1'b1;
            unl_cnt_q <= unl_cnt_q + 10'd1;
          end
`else
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`endif
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign wr_sel          = wr_sel_q;
  assign ram_write       = ram_write_q;
  assign write_address   = wr_addr_q;
  assign read_address    = rd_addr_q;
  assign twiddle_address = tw_q;
  assign bfly_start      = bfly_start_q;
`ifdef FFT_UNLOAD_EN
  assign out_valid       = out_valid_q;
`else
  assign out_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed self-checking bench for fft_sequencer. Runs a full
// transform, one aborted by reset in stage 4, and a full restart. A second
// instance with WB_LAT = 5 shares the stimulus to check the cycle budget.
module tb_fft_sequencer;

  localparam int WB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       load_valid = 1'b0;
  logic       busy, done, wr_sel, ram_write, bfly_start, out_valid;
  logic [8:0] write_address, read_address;
  logic [7:0] twiddle_address;
  logic       busy5, done5, wr_sel5, ram_write5, bfly_start5, out_valid5;
  logic [8:0] write_address5, read_address5;
  logic [7:0] twiddle_address5;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [8:0] ld_tab [5] = '{9'd0, 9'd256, 9'd128, 9'd384, 9'd64};
  logic [8:0] s1_rd  [8] = '{9'd0, 9'd2, 9'd1, 9'd3, 9'd4, 9'd6, 9'd5, 9'd7};
  logic [7:0] s1_tw  [8] = '{8'd0, 8'd0, 8'd128, 8'd128, 8'd0, 8'd0, 8'd128, 8'd128};
  logic [8:0] s8_rd  [4] = '{9'd0, 9'd256, 9'd1, 9'd257};
  logic [7:0] s8_tw  [4] = '{8'd0, 8'd0, 8'd1, 8'd1};

  fft_sequencer #(.WB_LAT(WB)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .load_valid(load_valid),
    .busy(busy), .done(done), .wr_sel(wr_sel), .ram_write(ram_write),
    .write_address(write_address), .read_address(read_address),
    .twiddle_address(twiddle_address), .bfly_start(bfly_start), .out_valid(out_valid)
  );

  fft_sequencer #(.WB_LAT(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .start(start), .load_valid(load_valid),
    .busy(busy5), .done(done5), .wr_sel(wr_sel5), .ram_write(ram_write5),
    .write_address(write_address5), .read_address(read_address5),
    .twiddle_address(twiddle_address5), .bfly_start(bfly_start5), .out_valid(out_valid5)
  );

  always #5 clk = ~clk;

  // Cycle index, stable while sampling on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  // Run-level monitor: compute window span, done pulses, out_valid beats
  logic mon_clr = 1'b0;
  int first4 = -1, last4 = -1, first5 = -1, last5 = -1;
  int dn4 = 0, dn5 = 0, ov4 = 0;
  always @(negedge clk) begin
    if (mon_clr) begin
      first4 <= -1; last4 <= -1; first5 <= -1; last5 <= -1;
      dn4 <= 0; dn5 <= 0; ov4 <= 0;
    end else begin
      if (bfly_start && first4 < 0) first4 <= cyc - 1;
      if (ram_write && !wr_sel) last4 <= cyc;
      if (bfly_start5 && first5 < 0) first5 <= cyc - 1;
      if (ram_write5 && !wr_sel5) last5 <= cyc;
      if (done) dn4 <= dn4 + 1;
      if (done5) dn5 <= dn5 + 1;
      if (out_valid) ov4 <= ov4 + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [8:0] rev9(input int v);
    logic [8:0] r;
    r = 9'd0;
    for (int b = 0; b < 9; b++) if (((v >> b) & 1) == 1) r = r | (9'd256 >> b);
    return r;
  endfunction

  // One transform; abort_s >= 0 pulls reset_n partway through that stage
  task automatic run_transform(input int abort_s);
    int k, i, tc, nc, span, ea, et, x;
    logic v;
    logic [8:0] a;
    logic wv [32];
    logic [8:0] wa [32];
    logic [8:0] first_ld [5];
    logic [8:0] cap_rd [8];
    logic [7:0] cap_tw [8];

    mon_clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
    check_eq("idle", {busy, done, ram_write, bfly_start}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", {busy, ram_write}, 32'd2);

    // LOAD with directed gaps
    k = 0; i = 0;
    while (k < 512) begin
      v = ((i % 7) != 3) && ((i % 11) != 5);
      i++;
      load_valid = v;
      a = rev9(k);
      if (v) k++;
      @(negedge clk);
      check_eq("load_wr", {busy, ram_write, wr_sel, bfly_start, done, (ram_write ? write_address : 9'd0)},
               {1'b1, v, v, 1'b0, 1'b0, (v ? a : 9'd0)});
      if (v && k <= 5) first_ld[k-1] = write_address;
    end
    load_valid = 1'b0;
    for (int n = 0; n < 5; n++) check_eq("load_first_addrs", first_ld[n], ld_tab[n]);

    // COMPUTE / DRAIN with a write-back scoreboard
    for (int n = 0; n < 32; n++) begin wv[n] = 1'b0; wa[n] = 9'd0; end
    tc = 0;
    for (int s = 0; s < 9; s++) begin
      span = 1 << s;
      load_valid = (s == 2);
      start = (s == 3);
      nc = 0;
      for (int g = 0; g < (256 >> s); g++) begin
        for (int j = 0; j < span; j++) begin
          for (int ph = 0; ph < 2; ph++) begin
            ea = g * 2 * span + j + ph * span;
            et = j * (256 >> s);
            @(negedge clk);
            check_eq("rd_tw", {read_address, twiddle_address}, {9'(ea), 8'(et)});
            check_eq("bfly_start", bfly_start, (ph == 1));
            x = tc % 32;
            check_eq("bfly_wr", {busy, ram_write, wr_sel, (ram_write ? write_address : 9'd0)},
                     {1'b1, wv[x], 1'b0, (wv[x] ? wa[x] : 9'd0)});
            wv[x] = 1'b0;
            wv[(tc + WB) % 32] = 1'b1;
            wa[(tc + WB) % 32] = 9'(ea);
            tc++;
            if (nc < 8) begin cap_rd[nc] = read_address; cap_tw[nc] = twiddle_address; end
            nc++;
            if (s == abort_s && nc == 41) begin
              #2 reset_n = 1'b0;
              #1;
              check_eq("async_rst", {busy, done, wr_sel, ram_write, write_address, read_address,
                                     twiddle_address, bfly_start, out_valid}, 32'd0);
              check_eq("async_rst5", {busy5, done5, wr_sel5, ram_write5, write_address5, read_address5,
                                      twiddle_address5, bfly_start5, out_valid5}, 32'd0);
              load_valid = 1'b0;
              start = 1'b0;
              repeat (3) @(negedge clk);
              reset_n = 1'b1;
              repeat (4) begin
                @(negedge clk);
                check_eq("post_rst_idle", {busy, ram_write, bfly_start, done, read_address}, 32'd0);
              end
              return;
            end
          end
        end
      end
      for (int d = 0; d < WB; d++) begin
        @(negedge clk);
        x = tc % 32;
        check_eq("drain_bs", bfly_start, 1'b0);
        check_eq("drain_wr", {ram_write, wr_sel, (ram_write ? write_address : 9'd0)},
                 {wv[x], 1'b0, (wv[x] ? wa[x] : 9'd0)});
        wv[x] = 1'b0;
        tc++;
      end
      if (s == 1) for (int n = 0; n < 8; n++) check_eq("s1_table", {cap_rd[n], cap_tw[n]}, {s1_rd[n], s1_tw[n]});
      if (s == 8) for (int n = 0; n < 4; n++) check_eq("s8_table", {cap_rd[n], cap_tw[n]}, {s8_rd[n], s8_tw[n]});
    end
    load_valid = 1'b0;
    start = 1'b0;

`ifdef FFT_UNLOAD_EN
    for (int u = 0; u < 512; u++) begin
      @(negedge clk);
      check_eq("unload_rd", {read_address, out_valid, ram_write, done}, {9'(u), (u > 0), 1'b0, 1'b0});
    end
    @(negedge clk);
    check_eq("unload_last_ov", {out_valid, done}, 32'd2);
`endif
    @(negedge clk);
    check_eq("done_pulse", {done, busy, out_valid}, 32'd4);
    @(negedge clk);
    check_eq("done_once", {done, busy}, 32'd0);

    for (int w = 0; w < 64 && dn5 == 0; w++) @(negedge clk);
    @(negedge clk);
    check_eq("dut5_done", dn5, 32'd1);
    check_eq("dn4_count", dn4, 32'd1);
    check_eq("compute_len_wb4", 32'(last4 - first4 + 1), 32'd4644);
    check_eq("compute_len_wb5", 32'(last5 - first5 + 1), 32'd4653);
`ifdef FFT_UNLOAD_EN
    check_eq("out_valid_beats", ov4, 32'd512);
`else
    check_eq("out_valid_beats", ov4, 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {busy, done, wr_sel, ram_write, write_address, read_address,
                               twiddle_address, bfly_start, out_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_after_reset", {busy, ram_write, done}, 32'd0);
    run_transform(-1);
    run_transform(4);
    run_transform(-1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control sequencer for the 512-point in-place radix-2 FFT. It owns the one-read/one-write 512×32 sample RAM and the 256×32 twiddle ROM:
- loads 512 samples into the RAM in bit-reversed order;
- sequences 9 butterfly stages of 256 butterflies each, generating RAM and ROM addresses and the write-enable stream for the butterfly datapath;
- optionally streams the result out.

It sits between the input sample interface, the memories and the butterfly unit.

## Interface
Parameters:
- WB_LAT, 4: cycles from issuing the A read address to writing A′. Legal range 2..16.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- load_valid  in  1  input sample present this cycle, during LOAD only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- wr_sel  out  1  datapath write-mux select: 1 selects the load sample, 0 selects the butterfly result.
- ram_write  out  1  RAM write enable.
- write_address  out  9  RAM write address.
- read_address  out  9  RAM read address.
- twiddle_address  out  8  ROM address.
- bfly_start  out  1  high in the cycle RAM q holds A and the ROM output holds W for a butterfly.
- out_valid  out  1  RAM q holds the unload word addressed in the previous cycle.

## Operation
States and transitions:
- IDLE → LOAD on start.
- LOAD → COMPUTE after 512 load_valid strobes.
- COMPUTE → DRAIN after the last read of a stage.
- DRAIN → COMPUTE with the next stage, or → UNLOAD / DONE after stage 8.
- UNLOAD → DONE after 512 reads.
- DONE → IDLE.

LOAD:
- Each load_valid strobe asserts ram_write and wr_sel in the same cycle, with write_address = bitrev9(load_cnt).
- load_cnt increments per strobe.
- Gaps in load_valid are allowed.

COMPUTE, stage s = 0..8, butterfly b = 0..255:
- span = 2^s, j = b & (span−1).
- iA = ((b>>s)<<(s+1)) | j; iB = iA + span.
- tw = j<<(8−s), truncated to 8 bits.
- Each butterfly takes 2 cycles. Cycle 0: read_address = iA, twiddle_address = tw. Cycle 1: read_address = iB, twiddle_address held.
- bfly_start is asserted one cycle after cycle 0.
- A′ is written to iA at WB_LAT cycles after cycle 0; B′ is written to iB one cycle later.
- wr_sel = 0 throughout COMPUTE and DRAIN.
- Write addresses and enables come from a WB_LAT+1-deep delay line of {addr, valid}.

DRAIN:
- No reads are issued.
- Lasts WB_LAT cycles after the last B read, so the final B′ write lands before the next stage's first read.
- The write delay line keeps shifting during DRAIN.

UNLOAD (FFT_UNLOAD_EN only):
- read_address = 0..511 sequentially, one per cycle.
- out_valid is asserted one cycle after each read is issued.

Boundary and exception rules:
- start is ignored while busy.
- load_valid is ignored outside LOAD.
- reset_n low at any point forces IDLE immediately. Every output goes to 0 and all counters and the delay line are cleared; no partial writes are issued after release.
- If start is high in the cycle after done, the sequencer returns to IDLE and begins a new LOAD.

## Timing
- Every output resets to 0, and every output is registered.
- COMPUTE plus DRAIN takes 9×(512+WB_LAT) cycles; this is 4644 cycles at the default WB_LAT.
- done is asserted in the cycle after the last write, or in the cycle after the last out_valid when FFT_UNLOAD_EN is defined.
- A read issued in the cycle after a write to the same address returns the new data. The DRAIN length depends on this.

## Configuration
FFT_UNLOAD_EN:
- Defined: the UNLOAD state is compiled in and out_valid is driven as described under UNLOAD.
- Undefined: DRAIN of stage 8 goes directly to DONE, out_valid is tied 0, and the host reads the RAM after done.

## Structure
Package fft_pkg holds:
- N_LOG2 = 9, N = 512;
- typedefs addr_t (logic [8:0]) and tw_addr_t (logic [7:0]);
- the state enum;
- a bitrev9 function.

Sub-module fft_addr_gen:
- inputs: stage, butterfly counter;
- outputs: iA, iB, tw;
- purely combinational; the sequencer registers its outputs.

## Test plan
- Reset → all outputs 0. Then start, then 512 load_valid strobes with random gaps → write_address sequence 0, 256, 128, 384, 64…, ram_write = wr_sel = 1 only on strobe cycles, busy = 1.
- Stage 0 → reads 0, 1, 2, 3…, twiddle 0 throughout. First write is addr 0 at WB_LAT cycles after the read of 0, then addr 1.
- Stage 1 → reads 0, 2, 1, 3, 4, 6, 5, 7…; twiddle 0, 0, 128, 128, 0, 0… Stage 8 → reads 0, 256, 1, 257…; twiddle 0, 0, 1, 1, 2, 2…
- Drain check → exactly WB_LAT read-free cycles between stages. Total compute 4644 cycles at WB_LAT = 4, and 4653 at WB_LAT = 5. done pulses once.
- reset_n low during stage 4 → outputs 0 asynchronously and state is IDLE. A full restart then produces sequences identical to the first three scenarios.
- With FFT_UNLOAD_EN → read_address 0..511 contiguous, out_valid lagging by 1, done in the cycle after the 512th out_valid. Without FFT_UNLOAD_EN → done right after the last stage and out_valid never asserted.
